// File: rtl/fpg8_control.sv
// fpg8_control
//   Hardwired control sequencer for the FPG8 single-bus datapath. Fetches an
//   instruction through MAR/MDR into IR (R7 is the PC), then runs the fixed
//   micro-step sequence for the IR opcode, driving every datapath strobe.
//
// Ports
//   one_shot_clock          datapath clock, all state changes on rising edge
//   reset                   synchronous active-high reset
//   start                   leaves IDLE when sampled high
//   bus_hold                debug driver owns the bus: freeze and blank strobes
//   opcode[3:0]             IR[15:12]
//   S                       shift direction (0 left, 1 right)
//   CC_N, CC_Z              comparator outputs for the current ALU result
//   ALU_control[2:0]        ALU function select
//   GPR_select[2:0]         register-file port select (Rd_1, Rd_2, Rs_1, Rs_2, R7)
//   GPR_in .. con_ROM_out   single-bit datapath strobes
//   flag_n, flag_z          latched condition flags
//   busy, halted, step[3:0] status: running, halted, cycle index in instruction
//
// Parameter
//   MEM_WAIT (1..4)         cycles each RAM read/write strobe is held

module fpg8_control #(
  parameter int MEM_WAIT = 1
) (
  input  logic       one_shot_clock,
  input  logic       reset,
  input  logic       start,
  input  logic       bus_hold,
  input  logic [3:0] opcode,
  input  logic       S,
  input  logic       CC_N,
  input  logic       CC_Z,
  output logic [2:0] ALU_control,
  output logic [2:0] GPR_select,
  output logic       GPR_in,
  output logic       GPR_out,
  output logic       IR_in,
  output logic       MAR_in,
  output logic       MDR_in,
  output logic       MDR_out,
  output logic       RAM_enable_read,
  output logic       RAM_enable_write,
  output logic       Y_in,
  output logic       Y_out,
  output logic       Y_offset_in,
  output logic       Y_shift_left,
  output logic       Y_shift_right,
  output logic       Z_in,
  output logic       Z_out,
  output logic       con_ROM_out,
  output logic       flag_n,
  output logic       flag_z,
  output logic       busy,
  output logic       halted,
  output logic [3:0] step
);

  localparam logic [2:0] ALU_PASS_BUS = 3'b000;
  localparam logic [2:0] ALU_NOT      = 3'b101;
  localparam logic [2:0] ALU_INC      = 3'b110;
  localparam logic [2:0] ALU_PASS_Y   = 3'b111;

  localparam logic [2:0] SEL_RD1 = 3'b000;
  localparam logic [2:0] SEL_RS1 = 3'b010;
  localparam logic [2:0] SEL_PC  = 3'b111;

  localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT - 1);

  typedef enum logic [2:0] {IDLE, F0, F1, F2, EX, HALTED} state_t;

  typedef struct packed {
    logic [2:0] alu;
    logic [2:0] sel;
    logic       gpr_in;
    logic       gpr_out;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       ram_rd;
    logic       ram_wr;
    logic       y_in;
    logic       y_shl;
    logic       y_shr;
    logic       z_in;
    logic       z_out;
    logic       rom_out;
    logic       flags_latch;
  } ctrl_t;

  state_t     state_reg, state_next;
  logic [2:0] e_reg, e_next;
  logic [1:0] wait_reg, wait_next;
  logic [3:0] step_reg, step_next;
  logic       flag_n_reg, flag_z_reg;

  ctrl_t      ctrl;
  ctrl_t      ctrl_out;
  logic       last_step;
  logic       mem_step;
  logic       wait_done;
  logic       br_taken;

  assign wait_done = (wait_reg == WAIT_LAST);
  assign br_taken  = (opcode == 4'hA) ||
                     (opcode == 4'hB && flag_z_reg) ||
                     (opcode == 4'hC && flag_n_reg);

  always_comb begin
    ctrl       = '0;
    state_next = state_reg;
    e_next     = e_reg;
    wait_next  = 2'd0;
    last_step  = 1'b0;
    mem_step   = 1'b0;
    step_next  = step_reg;

    case (state_reg)
      IDLE: begin
        if (start) state_next = F0;
      end

      F0: begin
        ctrl.sel     = SEL_PC;
        ctrl.gpr_out = 1'b1;
        ctrl.mar_in  = 1'b1;
        ctrl.alu     = ALU_INC;
        ctrl.z_in    = 1'b1;
        state_next   = F1;
      end

      F1: begin
        ctrl.ram_rd = 1'b1;
        // PC <- PC+1 only once, even when the read is stretched
        if (wait_reg == 2'd0) begin
          ctrl.z_out  = 1'b1;
          ctrl.gpr_in = 1'b1;
          ctrl.sel    = SEL_PC;
        end
        if (wait_done) state_next = F2;
        else           wait_next  = wait_reg + 2'd1;
      end

      F2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        state_next   = EX;
        e_next       = 3'd0;
      end

      EX: begin
        case (opcode)
          4'h1: begin  // LOAD
            case (e_reg)
              3'd0: begin ctrl.sel = SEL_RS1; ctrl.gpr_out = 1'b1; ctrl.mar_in = 1'b1; end
              3'd1: begin ctrl.ram_rd = 1'b1; mem_step = 1'b1; end
              default: begin
                ctrl.mdr_out = 1'b1; ctrl.gpr_in = 1'b1; ctrl.sel = SEL_RD1; last_step = 1'b1;
              end
            endcase
          end
          4'h2: begin  // STORE
            case (e_reg)
              3'd0: begin ctrl.sel = SEL_RS1; ctrl.gpr_out = 1'b1; ctrl.mar_in = 1'b1; end
              3'd1: begin ctrl.sel = SEL_RD1; ctrl.gpr_out = 1'b1; ctrl.mdr_in = 1'b1; end
              default: begin ctrl.ram_wr = 1'b1; mem_step = 1'b1; last_step = wait_done; end
            endcase
          end
          4'h3, 4'h4, 4'h5, 4'h6: begin  // ADD/SUB/AND/OR
            case (e_reg)
              3'd0: begin ctrl.sel = SEL_RS1; ctrl.gpr_out = 1'b1; ctrl.y_in = 1'b1; end
              3'd1: begin
                ctrl.sel = SEL_RD1; ctrl.gpr_out = 1'b1; ctrl.z_in = 1'b1;
                ctrl.alu = 3'(opcode - 4'd2);  // 3..6 map onto ALU codes 1..4
                ctrl.flags_latch = 1'b1;
              end
              default: begin
                ctrl.z_out = 1'b1; ctrl.gpr_in = 1'b1; ctrl.sel = SEL_RD1; last_step = 1'b1;
              end
            endcase
          end
          4'h7, 4'h8: begin  // NOT latches flags, MOV does not
            if (e_reg == 3'd0) begin
              ctrl.sel = SEL_RS1; ctrl.gpr_out = 1'b1; ctrl.z_in = 1'b1;
              ctrl.alu = (opcode == 4'h7) ? ALU_NOT : ALU_PASS_BUS;
              ctrl.flags_latch = (opcode == 4'h7);
            end else begin
              ctrl.z_out = 1'b1; ctrl.gpr_in = 1'b1; ctrl.sel = SEL_RD1; last_step = 1'b1;
            end
          end
          4'h9: begin  // SHIFT
            case (e_reg)
              3'd0: begin ctrl.sel = SEL_RS1; ctrl.gpr_out = 1'b1; ctrl.y_in = 1'b1; end
              3'd1: begin
                ctrl.y_shl = ~S; ctrl.y_shr = S;
                ctrl.alu = ALU_PASS_Y; ctrl.z_in = 1'b1; ctrl.flags_latch = 1'b1;
              end
              default: begin
                ctrl.z_out = 1'b1; ctrl.gpr_in = 1'b1; ctrl.sel = SEL_RD1; last_step = 1'b1;
              end
            endcase
          end
          4'hA, 4'hB, 4'hC: begin  // BR / BRZ / BRN
            if (!br_taken) begin
              last_step = 1'b1;
            end else if (e_reg == 3'd0) begin
              ctrl.sel = SEL_RS1; ctrl.gpr_out = 1'b1; ctrl.alu = ALU_PASS_BUS; ctrl.z_in = 1'b1;
            end else begin
              ctrl.z_out = 1'b1; ctrl.gpr_in = 1'b1; ctrl.sel = SEL_PC; last_step = 1'b1;
            end
          end
          4'hD: begin  // LDC
            ctrl.rom_out = 1'b1; ctrl.gpr_in = 1'b1; ctrl.sel = SEL_RD1; last_step = 1'b1;
          end
          default: begin  // NOP, reserved, HALT
            last_step = 1'b1;
          end
        endcase

        if (opcode == 4'hF)               state_next = HALTED;
        else if (last_step)               state_next = F0;
        else if (mem_step && !wait_done)  wait_next  = wait_reg + 2'd1;
        else                              e_next     = e_reg + 3'd1;
      end

      default: ;  // HALTED: only reset leaves
    endcase

    if (state_next == F0)
      step_next = 4'd0;
    else if (state_reg != IDLE && state_reg != HALTED && step_reg != 4'hF)
      step_next = step_reg + 4'd1;
  end

  always_ff @(posedge one_shot_clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      e_reg      <= 3'd0;
      wait_reg   <= 2'd0;
      step_reg   <= 4'd0;
      flag_n_reg <= 1'b0;
      flag_z_reg <= 1'b0;
    end else if (!bus_hold) begin
      state_reg <= state_next;
      e_reg     <= e_next;
      wait_reg  <= wait_next;
      step_reg  <= step_next;
      if (ctrl.flags_latch) begin
        flag_n_reg <= CC_N;
        flag_z_reg <= CC_Z;
      end
    end
  end

  // Strobes vanish combinationally during reset and bus_hold
  assign ctrl_out = (reset || bus_hold) ? '0 : ctrl;

  assign ALU_control      = ctrl_out.alu;
  assign GPR_select       = ctrl_out.sel;
  assign GPR_in           = ctrl_out.gpr_in;
  assign GPR_out          = ctrl_out.gpr_out;
  assign IR_in            = ctrl_out.ir_in;
  assign MAR_in           = ctrl_out.mar_in;
  assign MDR_in           = ctrl_out.mdr_in;
  assign MDR_out          = ctrl_out.mdr_out;
  assign RAM_enable_read  = ctrl_out.ram_rd;
  assign RAM_enable_write = ctrl_out.ram_wr;
  assign Y_in             = ctrl_out.y_in;
  assign Y_out            = 1'b0;
  assign Y_offset_in      = 1'b0;
  assign Y_shift_left     = ctrl_out.y_shl;
  assign Y_shift_right    = ctrl_out.y_shr;
  assign Z_in             = ctrl_out.z_in;
  assign Z_out            = ctrl_out.z_out;
  assign con_ROM_out      = ctrl_out.rom_out;

  assign flag_n = flag_n_reg;
  assign flag_z = flag_z_reg;
  assign busy   = (state_reg != IDLE) && (state_reg != HALTED);
  assign halted = (state_reg == HALTED);
  assign step   = step_reg;

endmodule

// File: doc/fpg8_control.md
# fpg8_control

Hardwired control sequencer for the FPG8 single-bus datapath. Each instruction is fetched from RAM through MAR/MDR into IR, then executed as a fixed micro-step sequence. The block drives every datapath control line (GPR, IR, MAR, MDR, RAM, Y, shifter, ALU, Z, constant ROM) from the IR opcode fields and an internal step state. R7 serves as the program counter. Condition flags are latched from the comparator.

## Interface
- MEM_WAIT, 1, cycles RAM_enable_read / RAM_enable_write are held per access; legal range 1..4.
- one_shot_clock  in  1  datapath clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset, sampled on one_shot_clock.
- start  in  1  leaves IDLE when sampled high.
- bus_hold  in  1  debug bus driver owns the bus; stall.
- opcode  in  4  IR[15:12].
- S  in  1  shift direction: 0 = left, 1 = right.
- CC_N, CC_Z  in  1 each  comparator outputs for the current ALU result.
- ALU_control  out  3  000 PASS_BUS, 001 ADD (bus+Y), 010 SUB (bus−Y), 011 AND, 100 OR, 101 NOT bus, 110 INC (bus+1), 111 PASS_Y.
- GPR_select  out  3  000 Rd_1, 001 Rd_2, 010 Rs_1, 011 Rs_2, 111 R7 (PC).
- GPR_in, GPR_out, IR_in, MAR_in, MDR_in, MDR_out, RAM_enable_read, RAM_enable_write, Y_in, Y_out, Y_offset_in, Y_shift_left, Y_shift_right, Z_in, Z_out, con_ROM_out  out  1 each  datapath strobes.
- flag_n, flag_z  out  1 each  latched condition flags.
- busy  out  1  high in every state except IDLE and HALTED.
- halted  out  1  high in HALTED.
- step  out  4  cycle index within the current instruction; 0 at F0; saturates at 15.

## Operation
- States: IDLE, F0, F1 (read wait), F2, E (execute, sub-step e = 0..5), HALTED.
- Outputs are a combinational decode of the state, sub-step and IR fields. All outputs are 0 in IDLE, in HALTED, while reset is high, and while bus_hold is high.
- At most one bus driver (GPR_out, MDR_out, Z_out, con_ROM_out) is active in any cycle.
- IDLE: go to F0 when start=1.
- F0:
  - GPR_out with select 7, MAR_in, ALU INC, Z_in.
- F1:
  - RAM_enable_read is held for MEM_WAIT cycles.
  - Z_out and GPR_in with select 7 assert in the first F1 cycle only, so PC ← PC+1.
- F2: MDR_out, IR_in. Then go to E, e=0.
- Execute steps, listed as e0; e1; e2. Instructions are Rd_1 ← Rd_1 op Rs_1 unless stated otherwise.
  - 0 NOP, E reserved: no strobes; end.
  - 1 LOAD (Rd_1 ← mem[Rs_1]):
    - e0: GPR_out Rs_1, MAR_in.
    - e1: RAM_enable_read held for MEM_WAIT cycles.
    - e2: MDR_out, GPR_in Rd_1.
  - 2 STORE (mem[Rs_1] ← Rd_1):
    - e0: GPR_out Rs_1, MAR_in.
    - e1: GPR_out Rd_1, MDR_in.
    - e2: RAM_enable_write held for MEM_WAIT cycles.
  - 3/4/5/6 ADD/SUB/AND/OR:
    - e0: GPR_out Rs_1, Y_in.
    - e1: GPR_out Rd_1, ALU op, Z_in, flags latch.
    - e2: Z_out, GPR_in Rd_1.
  - 7 NOT:
    - e0: GPR_out Rs_1, ALU NOT, Z_in, flags latch.
    - e1: Z_out, GPR_in Rd_1.
  - 8 MOV:
    - e0: GPR_out Rs_1, PASS_BUS, Z_in.
    - e1: Z_out, GPR_in Rd_1.
  - 9 SHIFT:
    - e0: GPR_out Rs_1, Y_in.
    - e1: Y_shift_left if S=0, otherwise Y_shift_right; PASS_Y, Z_in, flags latch.
    - e2: Z_out, GPR_in Rd_1.
  - A BR:
    - e0: GPR_out Rs_1, PASS_BUS, Z_in.
    - e1: Z_out, GPR_in select 7.
  - B BRZ / C BRN:
    - Same steps as BR when flag_z / flag_n is 1.
    - Otherwise no strobes and end after e0.
  - D LDC: e0: con_ROM_out, GPR_in Rd_1 (loads 8).
  - F HALT: go to HALTED.
- End of instruction: next state is F0. start is not re-sampled.
- HALTED: held until reset.
- Flags:
  - flag_n ← CC_N and flag_z ← CC_Z only on "flags latch" cycles.
  - Both flags are 0 after reset.
- Y_out and Y_offset_in are held 0.

## Timing
- Reset: at the first edge with reset=1, state ← IDLE, step ← 0, flags ← 0. Outputs are 0 from the cycle reset is asserted. Reset mid-instruction abandons it with no further strobes.
- Fetch takes 2+MEM_WAIT cycles. The opcode is valid from e0.
- Total cycles with MEM_WAIT=1:
  - 6: ADD/SUB/AND/OR, SHIFT, LOAD, STORE.
  - 5: NOT, MOV, BR, taken branch.
  - 4: NOP, untaken branch, LDC.
- bus_hold=1 at an edge freezes state, sub-step, wait counter, step and flags. The interrupted step replays in full after release.
- start=1 while busy or halted is ignored.

## Test plan
- Reset, then start with R7=0 and mem[0]=0x3xxx ADD (Rd_1=1, Rs_1=2), R1=5, R2=3 -> R1=8, R7=1, step 0..5 over 6 cycles, flag_z=0, flag_n=0.
- SUB with R1=R2=4 -> R1=0 and flag_z=1. A following BRZ to R3=0x20 -> R7=0x20 after 5 cycles. BRN with flag_n=0 -> R7 increments only, 4 cycles.
- STORE R1=0xABCD to address R2=0x10 with MEM_WAIT=3 -> RAM_enable_write high exactly 3 cycles. A later LOAD from 0x10 returns 0xABCD.
- bus_hold pulsed 2 cycles during ADD e1 -> every strobe 0 for those cycles, step frozen, final result identical and 2 cycles late.
- reset asserted at LOAD e1 -> outputs 0 that cycle, IDLE next cycle, and R7 keeps its incremented value.
- HALT (0xF000) -> halted=1, busy=0, all strobes 0. start pulses are ignored until reset.
